// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding and
// the byte-strobe legality rule that both the write commit and the read path use.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Naturally aligned byte, halfword and word strobes, plus the all-zero pattern.
  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// One byte lane of the data memory: synchronous write, synchronous read whose
// output register only updates on a read enable, so it holds the last read byte.
module dmem_byte_lane #(
  parameter int ADDR_W = 15
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**ADDR_W];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed read/write latency.
// Handshake: a transfer happens on a posedge where valid & ready are both high.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W        = 15,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WRITE_LATENCY - 1);

  if (READ_LATENCY < 1 || WRITE_LATENCY < 1) begin : g_lat_check
    $error("dmem_responder: READ_LATENCY and WRITE_LATENCY must be >= 1");
  end

  dmem_state_t       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rd_sel_q;

  logic              accept;
  logic              lat_one;
  logic              access;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata;
  logic              sel_legal;
  logic [3:0]        lane_we;
  logic              lane_re;
  logic [31:0]       lane_rdata;

  // A latency-1 access happens on the accept edge itself, so the array sees the
  // live request then; otherwise it sees the captured copy.
  assign accept    = (state_q == IDLE) && req_valid;
  assign lat_one   = req_we ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1);
  assign access    = (accept && lat_one) || ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
  assign sel_we    = accept ? req_we    : we_q;
  assign sel_addr  = accept ? req_addr  : addr_q;
  assign sel_be    = accept ? req_be    : be_q;
  assign sel_wdata = accept ? req_wdata : wdata_q;
  assign sel_legal = be_legal(sel_be);
  assign lane_we   = (access && sel_we && sel_legal) ? sel_be : 4'b0000;
  assign lane_re   = access && !sel_we;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    dmem_byte_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk_i   (clk),
      .we_i    (lane_we[i]),
      .re_i    (lane_re),
      .addr_i  (sel_addr),
      .wdata_i (sel_wdata[8*i +: 8]),
      .rdata_o (lane_rdata[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            be_q        <= req_be;
            wdata_q     <= req_wdata;
            cnt_q       <= req_we ? WR_CNT : RD_CNT;
            req_ready_q <= 1'b0;
            state_q     <= lat_one ? RESP : WAIT;
          end
        end
        WAIT: cnt_q <= cnt_q - CNT_W'(1);
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (access) begin
        state_q     <= RESP;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= !sel_legal;
        rd_sel_q    <= !sel_we && sel_legal;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = !req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_sel_q ? lane_rdata : 32'h0;
  assign dbg_state = state_q;

endmodule
